// File: rtl/rbm_gibbs_sequencer.sv
// Gibbs-iteration sequencer for the RBM inference datapath: alternates hidden and
// classification passes and accumulates per-unit votes. Optional layer watchdog: RBM_WATCHDOG_EN.
module rbm_gibbs_sequencer #(
    parameter int output_dim      = 2,
    parameter int bitlength       = 12,
    parameter int iteration_num   = 30,
    parameter int iter_width      = 8,
    parameter int watchdog_cycles = 255
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            data_valid,
    output logic                            load_input,
    output logic                            h_start,
    input  logic                            h_done,
    output logic                            c_start,
    input  logic                            c_done,
    input  logic [output_dim-1:0]           c_sample,
    output logic [output_dim*bitlength-1:0] VoteDataPort,
    output logic [iter_width-1:0]           iter_count,
    output logic                            busy,
    output logic                            finish,
    output logic                            error
);

    typedef enum logic [2:0] {IDLE, LOAD, H_RUN, C_RUN, DONE} state_t;

    localparam logic [iter_width-1:0] ITER_LAST = iter_width'(iteration_num);
    localparam logic [bitlength-1:0]  VOTE_MAX  = {bitlength{1'b1}};

    state_t                state;
    logic [iter_width-1:0] iter_next;
    logic                  h_accept;
    logic                  c_accept;

    function automatic logic [bitlength-1:0] vote_sat_inc(input logic [bitlength-1:0] v,
                                                          input logic              hit);
        if (hit && (v != VOTE_MAX))
            return v + bitlength'(1);
        return v;
    endfunction

    assign iter_next = iter_count + iter_width'(1);
    // A done in the same cycle as its start pulse belongs to no pass and is dropped
    assign h_accept  = (state == H_RUN) && h_done && !h_start;
    assign c_accept  = (state == C_RUN) && c_done && !c_start;

`ifdef RBM_WATCHDOG_EN
    localparam int              WD_W    = (watchdog_cycles > 1) ? $clog2(watchdog_cycles) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(watchdog_cycles - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_run;
    logic            wd_expired;

    assign wd_run     = (state == H_RUN) || (state == C_RUN);
    assign wd_expired = wd_run && !h_accept && !c_accept && (wd_cnt == WD_LAST);

    // Counter restarts on every state entry; only waiting cycles in a run state advance it
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
            error  <= 1'b0;
        end else begin
            if (wd_run && !h_accept && !c_accept && !wd_expired)
                wd_cnt <= wd_cnt + WD_W'(1);
            else
                wd_cnt <= '0;

            if ((state == IDLE) && data_valid)
                error <= 1'b0;
            else if (wd_expired)
                error <= 1'b1;
        end
    end
`else
    // No watchdog in this build: error is constant 0 for any legal watchdog_cycles
    assign error = (watchdog_cycles < 0);
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            load_input   <= 1'b0;
            h_start      <= 1'b0;
            c_start      <= 1'b0;
            VoteDataPort <= '0;
            iter_count   <= '0;
            busy         <= 1'b0;
            finish       <= 1'b0;
        end else begin
            load_input <= 1'b0;
            h_start    <= 1'b0;
            c_start    <= 1'b0;

            case (state)
                IDLE: begin
                    if (data_valid) begin
                        state        <= LOAD;
                        load_input   <= 1'b1;
                        busy         <= 1'b1;
                        VoteDataPort <= '0;
                        iter_count   <= '0;
                    end
                end
                LOAD: begin
                    state   <= H_RUN;
                    h_start <= 1'b1;
                end
                H_RUN: begin
                    if (h_accept) begin
                        state   <= C_RUN;
                        c_start <= 1'b1;
                    end
                end
                C_RUN: begin
                    if (c_accept) begin
                        for (int k = 0; k < output_dim; k++)
                            VoteDataPort[k*bitlength +: bitlength] <=
                                vote_sat_inc(VoteDataPort[k*bitlength +: bitlength], c_sample[k]);
                        iter_count <= iter_next;
                        if (iter_next == ITER_LAST) begin
                            state  <= DONE;
                            busy   <= 1'b0;
                            finish <= 1'b1;
                        end else begin
                            state   <= H_RUN;
                            h_start <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Requires data_valid to drop so a held-high level never retriggers
                    if (!data_valid) begin
                        state  <= IDLE;
                        finish <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    finish <= 1'b0;
                end
            endcase

`ifdef RBM_WATCHDOG_EN
            if (wd_expired) begin
                state  <= DONE;
                busy   <= 1'b0;
                finish <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_rbm_gibbs_sequencer.sv
// Bench for rbm_gibbs_sequencer: scripted layer responders, per-iteration scoreboard,
// and a second narrow-counter instance for vote saturation.
`timescale 1ns/1ps
module tb_rbm_gibbs_sequencer;
    localparam int OD = 2, BL = 12, ITER = 30, IW = 8, WD = 16;
    localparam int SBL = 3, SITER = 10, SIW = 4;

    typedef struct {
        logic [OD*BL-1:0] votes;
        logic [IW-1:0]    iter;
        logic             fin;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic             data_valid = 1'b0, h_done = 1'b0, c_done = 1'b0;
    logic [OD-1:0]    c_sample = '0;
    logic             load_input, h_start, c_start, busy, finish, error;
    logic [OD*BL-1:0] vote_data;
    logic [IW-1:0]    iter_count;

    logic              s_data_valid = 1'b0, s_h_done = 1'b0, s_c_done = 1'b0;
    logic [OD-1:0]     s_c_sample = '0;
    logic              s_load_input, s_h_start, s_c_start, s_busy, s_finish, s_error;
    logic [OD*SBL-1:0] s_votes;
    logic [SIW-1:0]    s_iter_count;

    rbm_gibbs_sequencer #(.output_dim(OD), .bitlength(BL), .iteration_num(ITER),
                          .iter_width(IW), .watchdog_cycles(WD)) dut (
        .clock(clock), .reset(reset), .data_valid(data_valid), .load_input(load_input),
        .h_start(h_start), .h_done(h_done), .c_start(c_start), .c_done(c_done),
        .c_sample(c_sample), .VoteDataPort(vote_data), .iter_count(iter_count),
        .busy(busy), .finish(finish), .error(error));

    rbm_gibbs_sequencer #(.output_dim(OD), .bitlength(SBL), .iteration_num(SITER),
                          .iter_width(SIW), .watchdog_cycles(WD)) dut_sat (
        .clock(clock), .reset(reset), .data_valid(s_data_valid), .load_input(s_load_input),
        .h_start(s_h_start), .h_done(s_h_done), .c_start(s_c_start), .c_done(s_c_done),
        .c_sample(s_c_sample), .VoteDataPort(s_votes), .iter_count(s_iter_count),
        .busy(s_busy), .finish(s_finish), .error(s_error));

    int checks = 0, errors = 0;
    int cyc = 0;
    int n_load, n_h, n_c, t_load, t_h, t_h_first, t_c_first, t_fin;
    logic [OD*BL-1:0] load_votes;
    logic [IW-1:0]    load_iter;
    logic             load_err;
    logic             fin_prev = 1'b0;
    int  h_cnt = 0, c_cnt = 0, mode = 0;
    bit  h_same = 0, stray = 0, noise = 0, wd_drop = 0;
    int  m_v0 = 0, m_v1 = 0, m_iter = 0;
    exp_t sb[$];
    bit  s_h_pend = 0, s_c_pend = 0;
    int  s_k = 0;

    function automatic logic [1:0] pattern(input int md, input int i);
        if (md == 0) return 2'b01;
        case (i % 3)
            0:       return 2'b01;
            1:       return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    // One clock cycle: observe outputs, pop due scoreboard entries, then drive layer responses
    task automatic step();
        exp_t e;
        logic [1:0] smp;
        @(negedge clock);
        cyc++;
        if (load_input) begin
            n_load++; t_load = cyc; load_votes = vote_data; load_iter = iter_count; load_err = error;
            m_v0 = 0; m_v1 = 0; m_iter = 0; sb.delete();
        end
        if (h_start) begin n_h++; t_h = cyc; if (n_h == 1) t_h_first = cyc; end
        if (c_start) begin n_c++; if (n_c == 1) t_c_first = cyc; end
        if (finish && !fin_prev) t_fin = cyc;
        fin_prev = finish;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (vote_data !== e.votes || iter_count !== e.iter || finish !== e.fin || busy !== !e.fin) begin
                errors++;
                $display("FAIL sb_iter%0d: got votes=%h iter=%0d finish=%b busy=%b, want votes=%h iter=%0d finish=%b busy=%b",
                         e.iter, vote_data, iter_count, finish, busy, e.votes, e.iter, e.fin, !e.fin);
            end
        end
        h_done = 1'b0;
        c_done = 1'b0;
        if (h_cnt > 0) begin h_cnt--; if (h_cnt == 0) h_done = 1'b1; end
        if (c_cnt > 0) begin
            c_cnt--;
            if (c_cnt == 0) begin
                smp = pattern(mode, m_iter);
                c_done = 1'b1; c_sample = smp;
                m_v0 += int'(smp[0]); m_v1 += int'(smp[1]); m_iter++;
                e.votes = {12'(m_v1), 12'(m_v0)}; e.iter = 8'(m_iter); e.fin = (m_iter == ITER);
                sb.push_back(e);
            end
        end
        if (h_start) begin
            if (!(wd_drop && m_iter == 4)) h_cnt = 3;
            if (h_same) h_done = 1'b1;
            if (stray) begin c_done = 1'b1; c_sample = 2'b11; end
        end
        if (c_start) begin
            c_cnt = 3;
            if (stray) h_done = 1'b1;
        end
        if (noise) begin h_done = 1'b1; c_done = 1'b1; c_sample = 2'b11; end
        s_h_done = s_h_pend;
        s_c_done = s_c_pend;
        if (s_c_pend) s_k++;
        s_c_sample = (s_k % 2 == 0) ? 2'b11 : 2'b01;
        s_h_pend = s_h_start;
        s_c_pend = s_c_start;
    endtask

    task automatic wait_finish(input string name, input int budget);
        int n = 0;
        while (finish !== 1'b1 && n < budget) begin step(); n++; end
        if (finish !== 1'b1) begin
            checks++; errors++;
            $display("FAIL %s_timeout: finish=%b after %0d cycles, want 1", name, finish, n);
        end
    endtask

    task automatic new_run(input int md);
        data_valid = 1'b0;
        repeat (3) step();
        mode = md; n_load = 0; n_h = 0; n_c = 0;
        data_valid = 1'b1;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #2;
        checks++;
        if ({load_input, h_start, c_start} !== 3'b000) begin errors++;
            $display("FAIL reset_pulses: got %b want 000", {load_input, h_start, c_start}); end
        checks++;
        if (vote_data !== '0) begin errors++; $display("FAIL reset_votes: got %h want 0", vote_data); end
        checks++;
        if (iter_count !== '0) begin errors++; $display("FAIL reset_iter: got %0d want 0", iter_count); end
        checks++;
        if ({busy, finish, error} !== 3'b000) begin errors++;
            $display("FAIL reset_status: got busy/finish/error=%b want 000", {busy, finish, error}); end
        checks++;
        if ({s_load_input, s_h_start, s_c_start, s_votes, s_iter_count, s_busy, s_finish, s_error} !== '0) begin
            errors++; $display("FAIL reset_sat_dut: got votes=%h iter=%0d want all 0", s_votes, s_iter_count); end
        repeat (2) step();
        reset = 1'b1;
    endtask

    task automatic test_basic();
        new_run(0);
        wait_finish("basic", 400);
        checks++;
        if (vote_data !== {12'd0, 12'd30}) begin errors++;
            $display("FAIL basic_votes: got %h want %h", vote_data, {12'd0, 12'd30}); end
        checks++;
        if (iter_count !== 8'd30) begin errors++; $display("FAIL basic_iter: got %0d want 30", iter_count); end
        checks++;
        if (n_h != 30 || n_c != 30 || n_load != 1) begin errors++;
            $display("FAIL basic_pulses: got h=%0d c=%0d load=%0d want 30 30 1", n_h, n_c, n_load); end
        checks++;
        if (busy !== 1'b0 || error !== 1'b0) begin errors++;
            $display("FAIL basic_status: got busy=%b error=%b want 0 0", busy, error); end
    endtask

    task automatic test_alternating();
        new_run(1);
        wait_finish("alternating", 400);
        checks++;
        if (load_votes !== '0) begin errors++; $display("FAIL alt_load_clear: got %h want 0", load_votes); end
        checks++;
        if (vote_data !== {12'd20, 12'd20}) begin errors++;
            $display("FAIL alt_votes: got %h want %h", vote_data, {12'd20, 12'd20}); end
        checks++;
        if (n_h != 30 || n_c != 30) begin errors++;
            $display("FAIL alt_pulses: got h=%0d c=%0d want 30 30", n_h, n_c); end
    endtask

    task automatic test_latency();
        int c0;
        data_valid = 1'b0;
        repeat (3) step();
        mode = 0; n_load = 0; n_h = 0; n_c = 0;
        h_same = 1; stray = 1;
        c0 = cyc;
        data_valid = 1'b1;
        wait_finish("latency", 400);
        h_same = 0; stray = 0;
        checks++;
        if (t_load - c0 != 1 || t_h_first - c0 != 2) begin errors++;
            $display("FAIL lat_start: got load@+%0d h_start@+%0d want +1 +2", t_load - c0, t_h_first - c0); end
        checks++;
        if (t_c_first - t_h_first != 4) begin errors++;
            $display("FAIL lat_same_cycle_done: got c_start %0d cycles after h_start, want 4", t_c_first - t_h_first); end
        checks++;
        if (vote_data !== {12'd0, 12'd30} || n_c != 30) begin errors++;
            $display("FAIL lat_stray_votes: got votes=%h c=%0d want %h 30", vote_data, n_c, {12'd0, 12'd30}); end
    endtask

    task automatic test_hold_restart();
        int base, n;
        base = n_load;
        noise = 1;
        repeat (20) step();
        checks++;
        if (finish !== 1'b1 || n_load != base) begin errors++;
            $display("FAIL hold_no_retrigger: got finish=%b loads=%0d want 1 %0d", finish, n_load, base); end
        checks++;
        if (vote_data !== {12'd0, 12'd30} || iter_count !== 8'd30) begin errors++;
            $display("FAIL hold_values: got votes=%h iter=%0d want %h 30", vote_data, iter_count, {12'd0, 12'd30}); end
        data_valid = 1'b0;
        repeat (3) step();
        noise = 0;
        checks++;
        if (finish !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL hold_to_idle: got finish=%b busy=%b want 0 0", finish, busy); end
        data_valid = 1'b1;
        n = 0;
        while (n_load == base && n < 6) begin step(); n++; end
        checks++;
        if (n_load != base + 1 || load_votes !== '0 || load_iter !== '0) begin errors++;
            $display("FAIL restart_clear: got loads=%0d votes=%h iter=%0d want %0d 0 0", n_load, load_votes, load_iter, base + 1); end
        wait_finish("restart", 400);
        checks++;
        if (vote_data !== {12'd0, 12'd30}) begin errors++;
            $display("FAIL restart_votes: got %h want %h", vote_data, {12'd0, 12'd30}); end
    endtask

    task automatic test_reset_midrun();
        int n = 0;
        new_run(0);
        while (n_c < 13 && n < 300) begin step(); n++; end
        checks++;
        if (iter_count !== 8'd12 || busy !== 1'b1) begin errors++;
            $display("FAIL midrun_pre: got iter=%0d busy=%b want 12 1", iter_count, busy); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({load_input, h_start, c_start, busy, finish, error} !== 6'b0 || vote_data !== '0 || iter_count !== '0) begin
            errors++; $display("FAIL midrun_async_clear: got votes=%h iter=%0d busy=%b want all 0", vote_data, iter_count, busy); end
        h_cnt = 0; c_cnt = 0; sb.delete(); m_v0 = 0; m_v1 = 0; m_iter = 0;
        repeat (3) step();
        checks++;
        if (finish !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL midrun_no_finish: got finish=%b busy=%b want 0 0", finish, busy); end
        reset = 1'b1;
        n_load = 0; n_h = 0; n_c = 0;
        wait_finish("after_reset", 400);
        checks++;
        if (vote_data !== {12'd0, 12'd30} || iter_count !== 8'd30 || n_h != 30) begin errors++;
            $display("FAIL after_reset_run: got votes=%h iter=%0d h=%0d want %h 30 30", vote_data, iter_count, n_h, {12'd0, 12'd30}); end
    endtask

    task automatic test_saturation();
        int n = 0;
        s_k = 0;
        s_data_valid = 1'b1;
        while (s_finish !== 1'b1 && n < 200) begin step(); n++; end
        checks++;
        if (s_finish !== 1'b1) begin errors++; $display("FAIL sat_timeout: finish=%b want 1", s_finish); end
        checks++;
        if (s_votes !== {3'd5, 3'd7}) begin errors++;
            $display("FAIL sat_votes: got %h want %h", s_votes, {3'd5, 3'd7}); end
        checks++;
        if (s_iter_count !== 4'd10 || s_busy !== 1'b0) begin errors++;
            $display("FAIL sat_iter: got iter=%0d busy=%b want 10 0", s_iter_count, s_busy); end
        s_data_valid = 1'b0;
        repeat (2) step();
    endtask

`ifdef RBM_WATCHDOG_EN
    task automatic test_watchdog();
        int base, n;
        new_run(0);
        wd_drop = 1;
        wait_finish("watchdog", 300);
        wd_drop = 0;
        checks++;
        if (error !== 1'b1 || iter_count !== 8'd4 || vote_data !== {12'd0, 12'd4}) begin errors++;
            $display("FAIL wd_expire: got error=%b iter=%0d votes=%h want 1 4 %h", error, iter_count, vote_data, {12'd0, 12'd4}); end
        checks++;
        if (t_fin - t_h != 16) begin errors++;
            $display("FAIL wd_latency: got finish %0d cycles after h_start, want 16", t_fin - t_h); end
        base = n_load;
        data_valid = 1'b0;
        repeat (3) step();
        data_valid = 1'b1;
        n = 0;
        while (n_load == base && n < 6) begin step(); n++; end
        checks++;
        if (load_err !== 1'b0) begin errors++; $display("FAIL wd_clear_on_load: got error=%b want 0", load_err); end
        wait_finish("wd_recover", 400);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_alternating();
        test_latency();
        test_hold_restart();
        test_reset_midrun();
        test_saturation();
`ifdef RBM_WATCHDOG_EN
        test_watchdog();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
